// File: rtl/demux1x4_tdm_pkg.sv
// Shared constants for the 4:1 TDM channel path.
// Slot geometry and FSM encodings used by both mux and demux sides.
package demux1x4_tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    localparam logic [SLOT_W-1:0] SLOT0 = '0;
    localparam logic [SLOT_W-1:0] SLOT1 = SLOT_W'(1);

endpackage

// File: rtl/demux1x4_tdm_demux1x4.sv
// Combinational 1-to-4 decoder.
// Turns an accept strobe and a slot index into per-slot write enables.
module demux1x4 (
    input  logic in,
    input  logic sel1,
    input  logic sel0,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3
);

    assign out0 = in & ~sel1 & ~sel0;
    assign out1 = in & ~sel1 &  sel0;
    assign out2 = in &  sel1 & ~sel0;
    assign out3 = in &  sel1 &  sel0;

endmodule

// File: rtl/demux1x4_tdm.sv
// TDM receive demux: stages four slots, publishes whole frames,
// and flags frame alignment loss with a sticky error.
module demux1x4_tdm
    import demux1x4_tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              frame_start,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] sel,
    output logic              sync_err
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] sel_q, sel_d;
    logic [SLOT_W-1:0] wslot;
    logic              accept;
    logic              err_set;
    logic [NCH-1:0]    we;
    logic [WIDTH-1:0]  stg_q [NCH-1];
    logic [WIDTH-1:0]  out_q [NCH];
    logic              fv_q;
    logic              err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_HUNT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (frame_start) begin
                        state_d = ST_COLLECT;
                        sel_d   = SLOT1;
                    end
                end
                ST_COLLECT: begin
                    if (frame_start) begin
                        sel_d = SLOT1;
                    end else if (sel_q == SLOT0) begin
                        state_d = ST_HUNT;
                    end else begin
                        // slot 3 wraps to 0 here, on completion only
                        sel_d = sel_q + SLOT1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        accept  = in_valid &
                  (frame_start |
                   (state_q == ST_COLLECT && sel_q != SLOT0));
        wslot   = frame_start ? SLOT0 : sel_q;
        err_set = in_valid && state_q == ST_COLLECT &&
                  (frame_start ? (sel_q != SLOT0) : (sel_q == SLOT0));
    end

    // we[3] can only fire for a non-start slot-3 sample: frame completion
    demux1x4 u_dec (
        .in   (accept),
        .sel1 (wslot[1]),
        .sel0 (wslot[0]),
        .out0 (we[0]),
        .out1 (we[1]),
        .out2 (we[2]),
        .out3 (we[3])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH - 1; i++) stg_q[i] <= '0;
            for (int i = 0; i < NCH; i++)     out_q[i] <= '0;
            fv_q  <= 1'b0;
            sel_q <= SLOT0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH - 1; i++) begin
                if (we[i]) stg_q[i] <= in_data;
            end
            if (we[3]) begin
                out_q[0] <= stg_q[0];
                out_q[1] <= stg_q[1];
                out_q[2] <= stg_q[2];
                out_q[3] <= in_data;
            end
            fv_q  <= we[3];
            sel_q <= sel_d;
            err_q <= err_set | (err_q & ~err_clr);
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = fv_q;
    assign sel         = sel_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Bench for demux1x4_tdm: directed scenarios plus random traffic,
// checked against a frame-level model and a completed-frame scoreboard.
module tb_demux1x4_tdm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       frame_start = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] out0, out1, out2, out3;
    logic       frame_valid;
    logic [1:0] sel;
    logic       sync_err;

    int npass = 0;
    int ntot  = 0;

    demux1x4_tdm #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_start (frame_start),
        .err_clr     (err_clr),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .sel         (sel),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view of the receiver
    bit         m_hunt = 1'b1;
    logic [7:0] m_part[$];
    bit         m_err = 1'b0;
    logic [31:0] m_last = '0;
    bit         m_done = 1'b0;
    logic [31:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_part.delete();
        m_err  = 1'b0;
        m_last = '0;
        m_done = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] d,
                              input bit fs, input bit clr);
        bit newerr = 1'b0;
        m_done = 1'b0;
        if (v) begin
            if (m_hunt) begin
                if (fs) begin
                    m_part.delete();
                    m_part.push_back(d);
                    m_hunt = 1'b0;
                end
            end else if (fs) begin
                if (m_part.size() != 0) newerr = 1'b1;
                m_part.delete();
                m_part.push_back(d);
            end else if (m_part.size() == 0) begin
                newerr = 1'b1;
                m_hunt = 1'b1;
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    m_last = {m_part[0], m_part[1], m_part[2], m_part[3]};
                    sb_q.push_back(m_last);
                    m_done = 1'b1;
                    m_part.delete();
                end
            end
        end
        m_err = newerr | (m_err & ~clr);
    endtask

    function automatic logic [1:0] m_sel();
        return m_hunt ? 2'd0 : 2'(m_part.size());
    endfunction

    task automatic step(input bit v, input logic [7:0] d,
                        input bit fs, input bit clr);
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        frame_start = fs;
        err_clr     = clr;
        @(posedge clk);
        model_step(v, d, fs, clr);
        #1;
        chk("sel", 32'(sel), 32'(m_sel()));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_done));
        chk("outs", {out0, out1, out2, out3}, m_last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [31:0] f, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(1, maxgap)));
            step(1'b1, f[31-8*i -: 8], i == 0, 1'b0);
        end
    endtask

    // Scoreboard monitor: each published frame must match the oldest expected
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            if (sb_q.size() == 0) begin
                ntot++;
                $display("FAIL sb_unexpected: got %0h expected none",
                         {out0, out1, out2, out3});
            end else begin
                chk("sb_frame", {out0, out1, out2, out3}, sb_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_outs", {out0, out1, out2, out3}, 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);

        // back-to-back frame
        frame(32'h11223344, 0);
        idle(2);
        // same frame with gaps
        frame(32'h11223344, 3);
        idle(1);
        // hunting drops unmarked samples
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        frame(32'h01020304, 0);
        // early start
        frame(32'h11223344, 0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        frame(32'h778899AA, 0);
        idle(1);
        // missing frame_start at slot 0, then clear interactions
        step(1'b0, 8'h00, 1'b0, 1'b1);
        frame(32'hC1C2C3C4, 0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        frame(32'hD1D2D3D4, 0);
        step(1'b1, 8'h5B, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);

        // async reset mid-frame with error set and outputs loaded
        frame(32'hE1E2E3E4, 0);
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_outs", {out0, out1, out2, out3}, 32'h0);
        chk("arst_sel", 32'(sel), 32'h0);
        chk("arst_fv", 32'(frame_valid), 32'h0);
        chk("arst_err", 32'(sync_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        frame(32'hF1F2F3F4, 1);

        // random traffic, mostly aligned frames
        for (int i = 0; i < 3000; i++) begin
            bit v   = $urandom_range(0, 3) != 0;
            bit fs;
            bit clr = $urandom_range(0, 15) == 0;
            if (m_sel() == 2'd0) fs = $urandom_range(0, 7) != 0;
            else                 fs = $urandom_range(0, 15) == 0;
            step(v, 8'($urandom), fs, clr);
        end
        idle(2);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
